// File: rtl/calc_core_n.sv
// ---------------------------------------------------------------------------
// calc_core_n
//   N-digit unsigned decimal calculator core. Commands arrive one at a time
//   over a valid/ready handshake. Supported operations are chained + - *,
//   with a shift-add multiplier and a double-dabble binary-to-BCD converter
//   that drives N seven-segment displays.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   cmd        in   0-9 digit, A '+', B '-', C '*', D reserved, E '=', F clear
//   cmd_valid  in   command present; accepted when cmd_valid & cmd_ready
//   cmd_ready  out  core can accept a command
//   displays   out  [0] = least significant digit, active-low {g,f,e,d,c,b,a}
//   status     out  00 ready, 01 busy, 10 error
//   digits     out  binary value currently shown
//
// State      | meaning
// -----------+-----------------------------------------------------------
// ENTER_A    | entering the first operand, or holding a '=' result
// ENTER_B    | entering the second operand; operator pending
// EXEC       | computing A op B (1 cycle for + and -, W cycles for *)
// CONV       | converting a value to BCD for the displays (W cycles)
// ERR        | overflow/underflow shown; only clear is honoured
// ---------------------------------------------------------------------------
module calc_core_n #(
    parameter int N_DIGITS = 8
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [3:0]                           cmd,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    output logic [N_DIGITS-1:0][6:0]             displays,
    output logic [1:0]                           status,
    output logic [$clog2(10**N_DIGITS)-1:0]      digits
);

    localparam int W  = $clog2(10**N_DIGITS);
    localparam int BW = 4 * N_DIGITS;
    localparam int CW = $clog2(W + 1);
    localparam int KW = $clog2(N_DIGITS + 1);

    localparam logic [W-1:0]  MAXV     = W'(10**N_DIGITS - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        CONV,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL
    } op_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Digit 0 gets one pattern, all higher digits another.
    function automatic logic [N_DIGITS-1:0][6:0] disp_fill(input logic [6:0] lo,
                                                          input logic [6:0] hi);
        logic [N_DIGITS-1:0][6:0] d;
        for (int i = 0; i < N_DIGITS; i++) begin
            d[i] = (i == 0) ? lo : hi;
        end
        return d;
    endfunction

    state_t                    r_state;
    state_t                    w_state_nxt;
    state_t                    r_ret;
    op_t                       r_op;
    op_t                       r_op_pend;
    logic                      r_eq;
    logic                      r_res_mode;
    logic [KW-1:0]             r_count;
    logic [CW-1:0]             r_cnt;
    logic [W-1:0]              r_acc;
    logic [W-1:0]              r_a;
    logic [W-1:0]              r_b;
    logic [2*W-1:0]            r_mcand;
    logic [W-1:0]              r_mplier;
    logic [2*W-1:0]            r_prod;
    logic [W-1:0]              r_bin;
    logic [BW-1:0]             r_bcd;
    logic [W-1:0]              r_conv_val;
    logic [N_DIGITS-1:0][6:0]  r_displays;
    logic [W-1:0]              r_digits;

    logic                      w_accept;
    logic                      w_is_digit;
    logic                      w_is_op;
    logic                      w_is_eq;
    logic                      w_is_clr;
    logic                      w_room;
    op_t                       w_cmd_op;
    logic                      w_in_entry;
    logic                      w_ev_clr;
    logic                      w_ev_digit;
    logic                      w_ev_op_a;
    logic                      w_ev_op_repl;
    logic                      w_ev_exec;
    logic [W-1:0]              w_acc_digit;
    logic [W:0]                w_sum;
    logic [W-1:0]              w_diff;
    logic [2*W-1:0]            w_prod_nxt;
    logic                      w_exec_done;
    logic [W-1:0]              w_exec_res;
    logic                      w_exec_err;
    logic [BW-1:0]             w_bcd_adj;
    logic [BW-1:0]             w_bcd_nxt;
    logic [N_DIGITS-1:0][6:0]  w_disp_new;

    // ---------------- command decode ----------------
    assign w_accept   = cmd_valid & cmd_ready;
    assign w_is_digit = (cmd <= 4'd9);
    assign w_is_op    = (cmd == 4'hA) || (cmd == 4'hB) || (cmd == 4'hC);
    assign w_is_eq    = (cmd == 4'hE);
    assign w_is_clr   = (cmd == 4'hF);
    assign w_room     = (r_count < KW'(N_DIGITS));
    assign w_in_entry = (r_state == ENTER_A) || (r_state == ENTER_B);

    always_comb begin
        w_cmd_op = OP_ADD;
        case (cmd)
            4'hB:    w_cmd_op = OP_SUB;
            4'hC:    w_cmd_op = OP_MUL;
            default: w_cmd_op = OP_ADD;
        endcase
    end

    assign w_ev_clr     = w_accept & w_is_clr;
    assign w_ev_digit   = w_accept & w_in_entry & w_is_digit & w_room;
    assign w_ev_op_a    = w_accept & (r_state == ENTER_A) & w_is_op;
    assign w_ev_op_repl = w_accept & (r_state == ENTER_B) & w_is_op & (r_count == '0);
    assign w_ev_exec    = w_accept & (r_state == ENTER_B) & (r_count != '0) & (w_is_op | w_is_eq);

    // After a '=' result the first digit starts a fresh number.
    assign w_acc_digit = (r_res_mode ? '0 : ((r_acc << 3) + (r_acc << 1))) + W'(cmd);

    // ---------------- arithmetic ----------------
    assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff     = r_a - r_b;
    assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);

    assign w_exec_done = (r_state == EXEC) && ((r_op != OP_MUL) || (r_cnt == '0));

    always_comb begin
        w_exec_res = '0;
        w_exec_err = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_exec_res = w_sum[W-1:0];
                w_exec_err = (w_sum > {1'b0, MAXV});
            end
            OP_SUB: begin
                w_exec_res = w_diff;
                w_exec_err = (r_b > r_a);
            end
            OP_MUL: begin
                w_exec_res = w_prod_nxt[W-1:0];
                w_exec_err = (w_prod_nxt > {{W{1'b0}}, MAXV});
            end
            default: begin
                w_exec_res = '0;
                w_exec_err = 1'b0;
            end
        endcase
    end

    // ---------------- double dabble step ----------------
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_nxt = (w_bcd_adj << 1) | BW'(r_bin[W-1]);

    // Segment patterns from the final BCD, blanking leading zeros.
    always_comb begin
        logic seen;
        seen       = 1'b0;
        w_disp_new = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (w_bcd_nxt[4*i +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            w_disp_new[i] = (seen || (i == 0)) ? seg7(w_bcd_nxt[4*i +: 4]) : 7'h7F;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ENTER_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ENTER_A, ENTER_B: begin
                if (w_ev_clr || w_ev_digit || w_ev_op_a || w_ev_op_repl) begin
                    w_state_nxt = CONV;
                end else if (w_ev_exec) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (w_exec_done) begin
                    w_state_nxt = w_exec_err ? ERR : CONV;
                end
            end
            CONV: begin
                if (r_cnt == '0) begin
                    w_state_nxt = r_ret;
                end
            end
            ERR: begin
                if (w_ev_clr) begin
                    w_state_nxt = CONV;
                end
            end
            default: w_state_nxt = ENTER_A;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        status    = 2'b00;
        case (r_state)
            ENTER_A, ENTER_B: cmd_ready = 1'b1;
            ERR: begin
                cmd_ready = 1'b1;
                status    = 2'b10;
            end
            EXEC, CONV: status = 2'b01;
            default: begin
                cmd_ready = 1'b0;
                status    = 2'b00;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ret      <= ENTER_A;
            r_op       <= OP_ADD;
            r_op_pend  <= OP_ADD;
            r_eq       <= 1'b0;
            r_res_mode <= 1'b0;
            r_count    <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_prod     <= '0;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_conv_val <= '0;
            r_displays <= disp_fill(7'h40, 7'h7F);
            r_digits   <= '0;
        end else if (w_ev_clr) begin
            r_op       <= OP_ADD;
            r_op_pend  <= OP_ADD;
            r_eq       <= 1'b0;
            r_res_mode <= 1'b0;
            r_count    <= '0;
            r_acc      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_prod     <= '0;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_conv_val <= '0;
            r_cnt      <= CNT_LOAD;
            r_ret      <= ENTER_A;
        end else if (w_ev_digit) begin
            r_acc      <= w_acc_digit;
            r_count    <= r_res_mode ? KW'(1) : r_count + KW'(1);
            r_res_mode <= 1'b0;
            r_bin      <= w_acc_digit;
            r_bcd      <= '0;
            r_conv_val <= w_acc_digit;
            r_cnt      <= CNT_LOAD;
            r_ret      <= r_state;
        end else if (w_ev_op_a) begin
            // Display keeps showing A until the first digit of B arrives.
            r_a        <= r_acc;
            r_op       <= w_cmd_op;
            r_acc      <= '0;
            r_count    <= '0;
            r_res_mode <= 1'b0;
            r_bin      <= r_acc;
            r_bcd      <= '0;
            r_conv_val <= r_acc;
            r_cnt      <= CNT_LOAD;
            r_ret      <= ENTER_B;
        end else if (w_ev_op_repl) begin
            r_op       <= w_cmd_op;
            r_bin      <= r_a;
            r_bcd      <= '0;
            r_conv_val <= r_a;
            r_cnt      <= CNT_LOAD;
            r_ret      <= ENTER_B;
        end else if (w_ev_exec) begin
            r_b        <= r_acc;
            r_op_pend  <= w_cmd_op;
            r_eq       <= w_is_eq;
            r_mcand    <= {{W{1'b0}}, r_a};
            r_mplier   <= r_acc;
            r_prod     <= '0;
            r_cnt      <= CNT_LOAD;
        end else if (r_state == EXEC) begin
            if (r_op == OP_MUL) begin
                r_prod   <= w_prod_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CW'(1);
            end
            if (w_exec_done) begin
                if (w_exec_err) begin
                    r_displays <= disp_fill(7'h06, 7'h3F);
                    r_digits   <= '0;
                end else begin
                    if (r_eq) begin
                        r_acc      <= w_exec_res;
                        r_res_mode <= 1'b1;
                        r_ret      <= ENTER_A;
                    end else begin
                        // Chained operator: result becomes A, new op goes live.
                        r_a   <= w_exec_res;
                        r_op  <= r_op_pend;
                        r_acc <= '0;
                        r_ret <= ENTER_B;
                    end
                    r_count    <= '0;
                    r_bin      <= w_exec_res;
                    r_bcd      <= '0;
                    r_conv_val <= w_exec_res;
                    r_cnt      <= CNT_LOAD;
                end
            end
        end else if (r_state == CONV) begin
            r_bcd <= w_bcd_nxt;
            r_bin <= r_bin << 1;
            r_cnt <= r_cnt - CW'(1);
            // Displays and digits change together, only when conversion completes.
            if (r_cnt == '0) begin
                r_displays <= w_disp_new;
                r_digits   <= r_conv_val;
            end
        end
    end

    assign displays = r_displays;
    assign digits   = r_digits;

endmodule

// File: tb/tb_calc_core_n.sv
module tb_calc_core_n;

    localparam int N  = 8;
    localparam int W  = 27;
    localparam int LD = W;        // digit / op-only / clear
    localparam int LE = W + 1;    // + or - with conversion
    localparam int LM = 2 * W;    // * with conversion

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [3:0]        cmd = 4'h0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [N-1:0][6:0] displays;
    logic [1:0]        status;
    logic [W-1:0]      digits;

    calc_core_n #(.N_DIGITS(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .displays  (displays),
        .status    (status),
        .digits    (digits)
    );

    always #5 clock = ~clock;

    int          n_total = 0;
    int          n_bad   = 0;
    int unsigned cyc     = 0;
    int unsigned t_acc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int unsigned       dig;
        logic [1:0]        st;
        logic [N-1:0][6:0] disp;
        int unsigned       lat;
    } exp_t;

    exp_t sb[$];

    function automatic logic [6:0] seg(input int unsigned d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [N-1:0][6:0] disp_of(input int unsigned v);
        logic [N-1:0][6:0] r;
        int unsigned rem;
        rem = v;
        for (int i = 0; i < N; i++) begin
            r[i] = (i == 0 || rem != 0) ? seg(rem % 10) : 7'h7F;
            rem  = rem / 10;
        end
        return r;
    endfunction

    function automatic logic [N-1:0][6:0] err_disp();
        logic [N-1:0][6:0] r;
        for (int i = 0; i < N; i++) r[i] = (i == 0) ? 7'h06 : 7'h3F;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every rise of cmd_ready marks a finished command.
    bit prev_rdy = 1'b1;
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            prev_rdy = 1'b1;
        end else begin
            if (!prev_rdy && cmd_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_done: digits=%0d with no pending expectation", digits);
                end else begin
                    e = sb.pop_front();
                    check("digits",   64'(digits),    64'(e.dig));
                    check("status",   64'(status),    64'(e.st));
                    check("displays", 64'(displays),  64'(e.disp));
                    check("latency",  64'(cyc - t_acc), 64'(e.lat));
                end
            end
            prev_rdy = cmd_ready;
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (cmd_ready) return;
        end
        n_total++;
        n_bad++;
        $display("FAIL timeout: cmd_ready still %0b after 200 cycles", cmd_ready);
    endtask

    // es==2 means the command is expected to end in the error state.
    task automatic send(input logic [3:0] c, input int unsigned ev, input logic [1:0] es,
                        input int unsigned lat, input bit ign);
        exp_t e;
        @(negedge clock);
        cmd       = c;
        cmd_valid = 1'b1;
        if (!ign) begin
            e.dig  = (es == 2'b10) ? 0 : ev;
            e.st   = es;
            e.disp = (es == 2'b10) ? err_disp() : disp_of(ev);
            e.lat  = lat;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        t_acc     = cyc;
        cmd_valid = 1'b0;
        if (ign) begin
            @(negedge clock);
            check("ign_ready",  64'(cmd_ready), 64'(1));
            check("ign_digits", 64'(digits),    64'(ev));
            check("ign_status", 64'(status),    64'(es));
        end else begin
            wait_ready();
        end
    endtask

    task automatic dg(input logic [3:0] d, input int unsigned ev);
        send(d, ev, 2'b00, LD, 1'b0);
    endtask

    initial begin
        // 1: reset
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_digits",   64'(digits),    64'(0));
        check("rst_status",   64'(status),    64'(0));
        check("rst_ready",    64'(cmd_ready), 64'(1));
        check("rst_displays", 64'(displays),  64'(disp_of(0)));

        send(4'hD, 0, 2'b00, 0, 1'b1);      // reserved: ignored
        send(4'hE, 0, 2'b00, 0, 1'b1);      // '=' with nothing pending: ignored

        // 2: digit entry
        dg(4'd1, 1);
        dg(4'd2, 12);
        dg(4'd3, 123);
        check("disp_123", 64'(displays), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30}));
        send(4'hF, 0, 2'b00, LD, 1'b0);

        // 3: 12 + 30 =
        dg(4'd1, 1);
        dg(4'd2, 12);
        send(4'hA, 12, 2'b00, LD, 1'b0);
        dg(4'd3, 3);
        dg(4'd0, 30);
        send(4'hE, 42, 2'b00, LE, 1'b0);
        // 2 + 3 + 4 =
        dg(4'd2, 2);
        send(4'hA, 2, 2'b00, LD, 1'b0);
        dg(4'd3, 3);
        send(4'hA, 5, 2'b00, LE, 1'b0);
        dg(4'd4, 4);
        send(4'hE, 9, 2'b00, LE, 1'b0);
        // continue from result, replace pending operator: 9 * -> - 4 = 5
        send(4'hC, 9, 2'b00, LD, 1'b0);
        send(4'hB, 9, 2'b00, LD, 1'b0);
        dg(4'd4, 4);
        send(4'hE, 5, 2'b00, LE, 1'b0);

        // 4: underflow
        send(4'hF, 0, 2'b00, LD, 1'b0);
        dg(4'd5, 5);
        send(4'hB, 5, 2'b00, LD, 1'b0);
        dg(4'd7, 7);
        send(4'hE, 0, 2'b10, 1, 1'b0);
        send(4'd1, 0, 2'b10, 0, 1'b1);      // digit ignored in error
        send(4'hF, 0, 2'b00, LD, 1'b0);

        // 5: 1234 * 5678 =
        dg(4'd1, 1);
        dg(4'd2, 12);
        dg(4'd3, 123);
        dg(4'd4, 1234);
        send(4'hC, 1234, 2'b00, LD, 1'b0);
        send(4'hE, 1234, 2'b00, 0, 1'b1);   // '=' with empty B: ignored
        dg(4'd5, 5);
        dg(4'd6, 56);
        dg(4'd7, 567);
        dg(4'd8, 5678);
        send(4'hE, 7006652, 2'b00, LM, 1'b0);
        send(4'hF, 0, 2'b00, LD, 1'b0);
        // 9999 * 99999 overflows
        dg(4'd9, 9);
        dg(4'd9, 99);
        dg(4'd9, 999);
        dg(4'd9, 9999);
        send(4'hC, 9999, 2'b00, LD, 1'b0);
        dg(4'd9, 9);
        dg(4'd9, 99);
        dg(4'd9, 999);
        dg(4'd9, 9999);
        dg(4'd9, 99999);
        send(4'hE, 0, 2'b10, W, 1'b0);
        send(4'hF, 0, 2'b00, LD, 1'b0);

        // 6: full entry, ninth digit dropped
        begin
            int unsigned v;
            v = 0;
            for (int i = 0; i < N; i++) begin
                v = v * 10 + 9;
                dg(4'd9, v);
            end
            send(4'd9, 99999999, 2'b00, 0, 1'b1);
        end
        send(4'hF, 0, 2'b00, LD, 1'b0);

        // reset in the middle of a multiply
        dg(4'd9, 9);
        dg(4'd9, 99);
        send(4'hC, 99, 2'b00, LD, 1'b0);
        dg(4'd9, 9);
        dg(4'd9, 99);
        @(negedge clock);
        cmd       = 4'hE;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        repeat (5) @(negedge clock);
        check("mid_busy", 64'(status), 64'(1));
        reset = 1'b0;
        #1;
        check("abort_digits",   64'(digits),    64'(0));
        check("abort_status",   64'(status),    64'(0));
        check("abort_ready",    64'(cmd_ready), 64'(1));
        check("abort_displays", 64'(displays),  64'(disp_of(0)));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("post_abort_digits", 64'(digits), 64'(0));

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
